// File: rtl/branch_predictor_gshare_spec_pkg.sv
// branch_predictor_gshare_spec_pkg: shared types, table geometry and helpers for the gshare predictor
package branch_predictor_gshare_spec_pkg;
    typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
    localparam int IDX_BITS = 10;
    localparam int HIST_BITS = 10;
    localparam int CTR_BITS = 2;
    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [HIST_BITS-1:0] ghr_t;
    typedef logic [CTR_BITS-1:0] ctr_t;
    localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (CTR_BITS - 1)) - 1);
    typedef struct packed {
        idx_t idx;
        ghr_t ghr;
        BranchOutcome pred;
    } bp_inflight_t;
    function automatic idx_t bp_index(idx_t pc_bits, ghr_t ghr, logic mode);
        return pc_bits ^ (mode ? idx_t'(ghr) : '0);
    endfunction
    function automatic ctr_t sat_update(ctr_t ctr, logic taken);
        return taken ? ((&ctr) ? ctr : ctr + 1'b1) : ((|ctr) ? ctr - 1'b1 : ctr);
    endfunction
endpackage

// File: rtl/branch_predictor_gshare_spec_if.sv
// branch_predictor_gshare_spec_if: predict/feedback/flush/stat bundle between branch_controller and predictor
interface branch_predictor_gshare_spec_if import branch_predictor_gshare_spec_pkg::*; #(
    parameter int ADDR_WIDTH = 32
);
    logic req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    BranchOutcome req_prediction;
    logic fb_valid;
    BranchOutcome fb_outcome;
    logic flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
    logic overflow;
    logic underflow;
    modport master (
        output req_valid, req_pc, fb_valid, fb_outcome, flush,
        input req_prediction, stat_branches, stat_mispred, overflow, underflow
    );
    modport slave (
        input req_valid, req_pc, fb_valid, fb_outcome, flush,
        output req_prediction, stat_branches, stat_mispred, overflow, underflow
    );
endinterface

// File: rtl/branch_predictor_gshare_spec_inflight_fifo.sv
// branch_predictor_gshare_spec_inflight_fifo: in-flight prediction FIFO; clear beats push and pop
module branch_predictor_gshare_spec_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [PW:0] count;
    assign head = mem[rd];
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/branch_predictor_gshare_spec.sv
// branch_predictor_gshare_spec: gshare/bimodal direction predictor with speculative GHR and checkpointed recovery
module branch_predictor_gshare_spec import branch_predictor_gshare_spec_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int PC_OFFSET = 2,
    parameter int DEPTH = 4,
    parameter bit MODE = 1'b1
) (
    input logic clk,
    input logic rst_n,
    branch_predictor_gshare_spec_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    ctr_t table_q [ENTRIES];
    ghr_t spec_ghr, commit_ghr, spec_next, commit_next;
    bp_inflight_t head;
    idx_t req_idx;
    logic [31:0] branches, mispreds;
    logic overflow, underflow, full, empty;
    logic fb_fire, fb_taken, pred_taken, mispred, squash, accept;
    logic unused_pc;
    assign unused_pc = ^bus.req_pc;
    assign req_idx = bp_index(bus.req_pc[IDX_BITS+PC_OFFSET-1:PC_OFFSET], spec_ghr, MODE);
    assign pred_taken = table_q[req_idx][CTR_BITS-1];
    assign bus.req_prediction = BranchOutcome'(pred_taken);
    assign fb_fire = bus.fb_valid && !empty;
    assign fb_taken = bus.fb_outcome == TAKEN;
    assign mispred = fb_fire && (fb_taken != (head.pred == TAKEN));
    assign squash = mispred || bus.flush;
    // a correct same-cycle pop frees a slot, so a full FIFO still accepts
    assign accept = bus.req_valid && !squash && (!full || fb_fire);
    assign bus.stat_branches = branches;
    assign bus.stat_mispred = mispreds;
    assign bus.overflow = overflow;
    assign bus.underflow = underflow;
    always_comb begin
        commit_next = fb_fire ? ghr_t'({commit_ghr, fb_taken}) : commit_ghr;
        spec_next = bus.flush ? commit_next :
                    mispred   ? ghr_t'({head.ghr, fb_taken}) :
                    accept    ? ghr_t'({spec_ghr, pred_taken}) : spec_ghr;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_WEAK_NT;
            spec_ghr <= '0;
            commit_ghr <= '0;
            branches <= '0;
            mispreds <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fb_fire) table_q[head.idx] <= sat_update(table_q[head.idx], fb_taken);
            spec_ghr <= spec_next;
            commit_ghr <= commit_next;
            if (fb_fire && ~&branches) branches <= branches + 1'b1;
            if (mispred && ~&mispreds) mispreds <= mispreds + 1'b1;
            if (bus.req_valid && !squash && full && !fb_fire) overflow <= 1'b1;
            if (bus.fb_valid && empty) underflow <= 1'b1;
        end
    end
    branch_predictor_gshare_spec_inflight_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(bp_inflight_t))
    ) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(accept),
        .pop(fb_fire),
        .clear(squash),
        .din({req_idx, spec_ghr, BranchOutcome'(pred_taken)}),
        .head(head),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_branch_predictor_gshare_spec.sv
// tb_branch_predictor_gshare_spec: bimodal and gshare instances on one stimulus stream, checked against a queue-based model
module tb_branch_predictor_gshare_spec;
    import branch_predictor_gshare_spec_pkg::*;
    typedef struct {int idx; int ghr; int pred;} ent_t;
    logic clk, rst_n, req_valid, fb_valid, fb_t, flush;
    logic [31:0] req_pc;
    int passed, total;
    bit started;
    int tbl [2][1024];
    int sghr [2];
    int cghr [2];
    longint br [2];
    longint mp [2];
    bit ovf [2];
    bit udf [2];
    ent_t q [2][$];
    branch_predictor_gshare_spec_if bus0 ();
    branch_predictor_gshare_spec_if bus1 ();
    assign bus0.req_valid = req_valid;
    assign bus0.req_pc = req_pc;
    assign bus0.fb_valid = fb_valid;
    assign bus0.fb_outcome = BranchOutcome'(fb_t);
    assign bus0.flush = flush;
    assign bus1.req_valid = req_valid;
    assign bus1.req_pc = req_pc;
    assign bus1.fb_valid = fb_valid;
    assign bus1.fb_outcome = BranchOutcome'(fb_t);
    assign bus1.flush = flush;
    branch_predictor_gshare_spec #(.MODE(1'b0)) d0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    branch_predictor_gshare_spec #(.MODE(1'b1)) d1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask
    function automatic int m_idx(int m);
        return (int'(req_pc >> 2) & 1023) ^ (m == 1 ? sghr[m] : 0);
    endfunction
    function automatic int m_pred(int m);
        return tbl[m][m_idx(m)] >= 2 ? 1 : 0;
    endfunction
    // the model consumes this cycle's inputs at the clock edge, same as the DUT
    task automatic m_step(int m);
        int idx, pred, nc;
        bit mis;
        ent_t h, e;
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) tbl[m][i] = 1;
            sghr[m] = 0;
            cghr[m] = 0;
            q[m].delete();
            br[m] = 0;
            mp[m] = 0;
            ovf[m] = 0;
            udf[m] = 0;
            return;
        end
        idx = m_idx(m);
        pred = m_pred(m);
        nc = cghr[m];
        mis = 0;
        if (fb_valid && q[m].size() == 0) udf[m] = 1;
        if (fb_valid && q[m].size() > 0) begin
            h = q[m].pop_front();
            tbl[m][h.idx] = fb_t ? (tbl[m][h.idx] < 3 ? tbl[m][h.idx] + 1 : 3)
                                 : (tbl[m][h.idx] > 0 ? tbl[m][h.idx] - 1 : 0);
            nc = ((cghr[m] << 1) | int'(fb_t)) & 1023;
            if (br[m] < 64'hFFFF_FFFF) br[m]++;
            if (int'(fb_t) != h.pred) begin
                mis = 1;
                if (mp[m] < 64'hFFFF_FFFF) mp[m]++;
            end
        end
        if (flush) begin
            q[m].delete();
            sghr[m] = nc;
        end else if (mis) begin
            q[m].delete();
            sghr[m] = ((h.ghr << 1) | int'(fb_t)) & 1023;
        end else if (req_valid) begin
            if (q[m].size() < 4) begin
                e.idx = idx;
                e.ghr = sghr[m];
                e.pred = pred;
                q[m].push_back(e);
                sghr[m] = ((sghr[m] << 1) | pred) & 1023;
            end else ovf[m] = 1;
        end
        cghr[m] = nc;
    endtask
    always @(posedge clk) begin
        if (!rst_n) started = 1;
        for (int m = 0; m < 2; m++) m_step(m);
    end
    task automatic cmp(int m, longint pred, longint b, longint mpv, longint ov, longint uf, longint g);
        chk($sformatf("pred_m%0d", m), pred, m_pred(m));
        chk($sformatf("branches_m%0d", m), b, br[m]);
        chk($sformatf("mispred_m%0d", m), mpv, mp[m]);
        chk($sformatf("overflow_m%0d", m), ov, ovf[m]);
        chk($sformatf("underflow_m%0d", m), uf, udf[m]);
        chk($sformatf("spec_ghr_m%0d", m), g, sghr[m]);
    endtask
    always @(negedge clk) begin
        if (started) begin
            cmp(0, bus0.req_prediction, bus0.stat_branches, bus0.stat_mispred, bus0.overflow, bus0.underflow, d0.spec_ghr);
            cmp(1, bus1.req_prediction, bus1.stat_branches, bus1.stat_mispred, bus1.overflow, bus1.underflow, d1.spec_ghr);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        req_valid = 0;
        req_pc = '0;
        fb_valid = 0;
        fb_t = 0;
        flush = 0;
    endtask
    task automatic req(logic [31:0] pc);
        req_valid = 1;
        req_pc = pc;
    endtask
    task automatic fb(logic t);
        fb_valid = 1;
        fb_t = t;
    endtask
    initial begin
        rst_n = 0;
        idle();
        tick();
        tick();
        rst_n = 1;
        // reset state and first cold prediction
        req(32'h400);
        #1;
        chk("t1_pred_bimodal", bus0.req_prediction, 0);
        chk("t1_pred_gshare", bus1.req_prediction, 0);
        chk("t1_branches", bus0.stat_branches, 0);
        chk("t1_mispred", bus0.stat_mispred, 0);
        chk("t1_overflow", bus0.overflow, 0);
        chk("t1_underflow", bus0.underflow, 0);
        tick();
        idle();
        fb(1);
        tick();
        idle();
        // bimodal warm-up: counter 2 then 3 predicts taken
        for (int i = 0; i < 2; i++) begin
            req(32'h400);
            #1;
            chk("t2_pred_taken", bus0.req_prediction, 1);
            tick();
            idle();
            fb(1);
            tick();
            idle();
        end
        chk("t2_branches", bus0.stat_branches, 3);
        chk("t2_mispred", bus0.stat_mispred, 1);
        chk("t2_model_ctr", tbl[0][256], 3);
        chk("t2_gshare_ghr", d1.spec_ghr, 7);
        // three in flight, oldest mispredicts with a wrong-path request alongside
        for (int i = 0; i < 3; i++) begin
            req(32'h800);
            #1;
            chk("t3_pred_nt", bus1.req_prediction, 0);
            tick();
        end
        idle();
        chk("t3_ghr_before", d1.spec_ghr, 56);
        req(32'h800);
        fb(1);
        tick();
        idle();
        chk("t3_ghr_restored", d1.spec_ghr, 15);
        chk("t3_model_ghr", sghr[1], 15);
        chk("t3_empty", d1.empty, 1);
        chk("t3_model_empty", q[1].size(), 0);
        chk("t3_mispred", bus1.stat_mispred, 4);
        // five requests into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            req(32'hC00);
            #1;
            chk("t4_pred", bus1.req_prediction, 0);
            if (i == 4) chk("t4_no_overflow_yet", bus1.overflow, 0);
            tick();
        end
        idle();
        chk("t4_overflow_gshare", bus1.overflow, 1);
        chk("t4_overflow_bimodal", bus0.overflow, 1);
        chk("t4_ghr", d1.spec_ghr, 240);
        flush = 1;
        tick();
        idle();
        chk("t5_pre_ghr", d1.spec_ghr, 15);
        // feedback with nothing in flight
        fb(1);
        tick();
        idle();
        chk("t5_underflow", bus1.underflow, 1);
        chk("t5_underflow_bimodal", bus0.underflow, 1);
        chk("t5_branches", bus1.stat_branches, 4);
        chk("t5_mispred", bus1.stat_mispred, 4);
        chk("t5_mispred_bimodal", bus0.stat_mispred, 2);
        chk("t5_ghr", d1.spec_ghr, 15);
        // reset mid-operation, then flush recovery to commit_ghr = 1
        req(32'h400);
        tick();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6_reset_overflow", bus1.overflow, 0);
        chk("t6_reset_underflow", bus1.underflow, 0);
        chk("t6_reset_branches", bus1.stat_branches, 0);
        chk("t6_reset_ghr", d1.spec_ghr, 0);
        chk("t6_reset_empty", d1.empty, 1);
        req(32'h400);
        #1;
        chk("t6_pred_cold", bus1.req_prediction, 0);
        tick();
        idle();
        fb(1);
        tick();
        idle();
        req(32'h400);
        tick();
        req(32'h400);
        tick();
        idle();
        chk("t6_ghr_spec", d1.spec_ghr, 4);
        flush = 1;
        tick();
        idle();
        chk("t6_ghr_flush", d1.spec_ghr, 1);
        chk("t6_empty", d1.empty, 1);
        req(32'h404);
        #1;
        chk("t6_pred_ghr1", bus1.req_prediction, 1);
        tick();
        idle();
        // mixed traffic exercising saturation, full-with-pop and flush interplay
        for (int i = 0; i < 80; i++) begin
            req_valid = (i % 3) != 2;
            req_pc = 32'h400 + 32'((i % 5) * 4);
            fb_valid = (i % 2) == 1;
            fb_t = (i % 7) < 3;
            flush = (i % 29) == 28;
            tick();
        end
        idle();
        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
